// File: rtl/alu_seq_unit_if.sv
// Request/response bundle for alu_seq_unit: the request side carries the
// operands and function code, the response side the result and its flags.
interface alu_seq_unit_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] rs1_data_i;
  logic [DATA_W-1:0] rs2_data_i;
  logic [OP_W-1:0]   func_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              zero_o;
  logic              err_o;

  // Issuing side: decode/register-read stage plus writeback consumer.
  modport master (
    output in_valid_i, rs1_data_i, rs2_data_i, func_i, out_ready_i,
    input  in_ready_o, out_valid_o, rd_data_o, zero_o, err_o
  );

  // The ALU itself.
  modport slave (
    input  in_valid_i, rs1_data_i, rs2_data_i, func_i, out_ready_i,
    output in_ready_o, out_valid_o, rd_data_o, zero_o, err_o
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, 1-bit-per-cycle
// shifts, registered result with zero/error flags held until writeback.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | ready for a request; in_ready_o high
//   S_SHIFT | shifting accumulator one bit per cycle until count reaches 0
//   S_RESP  | result valid, held until the consumer takes it
module alu_seq_unit #(
  parameter  int DATA_W = 32,
  parameter  int OP_W   = 4,
  localparam int SH_W   = $clog2(DATA_W)
) (
  input logic           clk_i,
  input logic           arst_i,
  alu_seq_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_RESP} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_acc;
  logic [SH_W-1:0]   r_cnt;
  logic              r_dir_left;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_err;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_op_valid;
  logic              w_is_shift;
  logic [SH_W-1:0]   w_amount;
  logic [DATA_W-1:0] w_alu_res;
  logic [DATA_W-1:0] w_acc_next;

  assign w_accept   = bus.in_valid_i && (r_state == S_IDLE);
  // Codes 0-7 are defined; anything with a bit set above bit 2 is invalid.
  assign w_op_valid = ((bus.func_i >> 3) == '0);
  assign w_is_shift = w_op_valid && (bus.func_i[2:1] == 2'b11);
  assign w_amount   = bus.rs2_data_i[SH_W-1:0];
  assign w_acc_next = r_dir_left ? (r_acc << 1) : (r_acc >> 1);

  // Single-cycle result for logic/arith ops; invalid codes yield zero.
  always_comb begin
    w_alu_res = '0;
    if (w_op_valid) begin
      case (bus.func_i[2:0])
        3'd0:    w_alu_res = bus.rs1_data_i & bus.rs2_data_i;
        3'd1:    w_alu_res = bus.rs1_data_i | bus.rs2_data_i;
        3'd2:    w_alu_res = bus.rs1_data_i ^ bus.rs2_data_i;
        3'd3:    w_alu_res = ~bus.rs1_data_i;
        3'd4:    w_alu_res = bus.rs1_data_i + bus.rs2_data_i;
        3'd5:    w_alu_res = bus.rs1_data_i - bus.rs2_data_i;
        default: w_alu_res = '0;
      endcase
    end
  end

  // Control FSM with registered result, flags and output-valid.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_dir_left  <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_shift) begin
              r_acc      <= bus.rs1_data_i;
              r_cnt      <= w_amount;
              // SLL is code 6 (bit0 clear), SRL is code 7.
              r_dir_left <= ~bus.func_i[0];
              if (w_amount == '0) begin
                r_result    <= bus.rs1_data_i;
                r_zero      <= (bus.rs1_data_i == '0);
                r_err       <= 1'b0;
                r_out_valid <= 1'b1;
                r_state     <= S_RESP;
              end else begin
                r_state <= S_SHIFT;
              end
            end else begin
              r_result    <= w_alu_res;
              r_zero      <= (w_alu_res == '0);
              r_err       <= ~w_op_valid;
              r_out_valid <= 1'b1;
              r_state     <= S_RESP;
            end
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - SH_W'(1);
          if (r_cnt == SH_W'(1)) begin
            r_result    <= w_acc_next;
            r_zero      <= (w_acc_next == '0);
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          // Return to IDLE only; the next request is taken a cycle later.
          if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = (r_state == S_IDLE);
  assign bus.out_valid_o = r_out_valid;
  assign bus.rd_data_o   = r_result;
  assign bus.zero_o      = r_zero;
  assign bus.err_o       = r_err;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed vector table, hand-written
// reset/backpressure/abort sequences, and random ops against a reference model.
module tb_alu_seq_unit;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  logic clk_i  = 1'b0;
  logic arst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  alu_seq_unit_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus();

  alu_seq_unit #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk_i (clk_i),
    .arst_i(arst_i),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  f;
    logic [31:0] r;
    logic        z;
    logic        e;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        e;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the operation rules stated directly as arithmetic.
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                                 output logic [31:0] r, output logic z, output logic e,
                                 output int lat);
    int amt;
    amt = int'(b[4:0]);
    e   = 1'b0;
    lat = 1;
    case (f)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: r = ~a;
      4'd4: r = a + b;
      4'd5: r = a - b;
      4'd6: begin r = a << amt; lat = 1 + amt; end
      4'd7: begin r = a >> amt; lat = 1 + amt; end
      default: begin r = '0; e = 1'b1; end
    endcase
    z = (r == '0);
  endfunction

  // Issue one op from a negedge with the unit idle, check latency, busy,
  // result stability under hold cycles of backpressure, then drain it.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                       input logic [31:0] er, input logic ez, input logic ee, input int elat,
                       input int hold, input string tag);
    exp_t        ex;
    int          guard;
    int          lat;
    logic        busy_ok;
    logic        stable_ok;
    logic [31:0] first;
    guard = 0;
    while (!bus.in_ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    check({tag, " idle_before"}, bus.in_ready_o, 1);
    ex.r = er; ex.z = ez; ex.e = ee;
    sb.push_back(ex);
    bus.in_valid_i = 1'b1;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.func_i     = f;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    bus.rs1_data_i = $urandom;
    bus.rs2_data_i = $urandom;
    bus.func_i     = 4'($urandom);
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid_o && lat < 100) begin
      if (bus.in_ready_o) busy_ok = 1'b0;
      @(negedge clk_i);
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " busy"}, busy_ok, 1);
    check({tag, " ready_in_resp"}, bus.in_ready_o, 0);
    first     = bus.rd_data_o;
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      if (bus.rd_data_o !== first || !bus.out_valid_o) stable_ok = 1'b0;
    end
    if (hold > 0) check({tag, " stable"}, stable_ok, 1);
    ex = sb.pop_front();
    check({tag, " rd_data"}, bus.rd_data_o, ex.r);
    check({tag, " zero"}, bus.zero_o, ex.z);
    check({tag, " err"}, bus.err_o, ex.e);
    bus.out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.out_ready_i = 1'b0;
    check({tag, " back_idle"}, {bus.in_ready_o, bus.out_valid_o}, 2'b10);
  endtask

  vec_t vt[14];

  initial begin
    logic        busy_ok;
    logic        stable_ok;
    logic        no_valid;
    logic [31:0] ra, rb, rr;
    logic [3:0]  rf;
    logic        rz, re;
    int          rlat;

    vt[0]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd0, 32'h00F0_00F0, 1'b0, 1'b0, 1};
    vt[1]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd1, 32'hFFF0_FFF0, 1'b0, 1'b0, 1};
    vt[2]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd2, 32'hFF00_FF00, 1'b0, 1'b0, 1};
    vt[3]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd3, 32'h0F0F_0F0F, 1'b0, 1'b0, 1};
    vt[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd4, 32'h0000_0000, 1'b1, 1'b0, 1};
    vt[5]  = '{32'h0000_0000, 32'h0000_0001, 4'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};
    vt[6]  = '{32'h0000_0001, 32'h0000_001F, 4'd6, 32'h8000_0000, 1'b0, 1'b0, 32};
    vt[7]  = '{32'h8000_0000, 32'h0000_0004, 4'd7, 32'h0800_0000, 1'b0, 1'b0, 5};
    vt[8]  = '{32'h1234_5678, 32'hFFFF_FFE0, 4'd6, 32'h1234_5678, 1'b0, 1'b0, 1};
    vt[9]  = '{32'h0000_1234, 32'h0000_0005, 4'd9, 32'h0000_0000, 1'b1, 1'b1, 1};
    vt[10] = '{32'h0000_0001, 32'h0000_0001, 4'd4, 32'h0000_0002, 1'b0, 1'b0, 1};
    vt[11] = '{32'h0000_0003, 32'h0000_0001, 4'd7, 32'h0000_0001, 1'b0, 1'b0, 2};
    vt[12] = '{32'h0000_0005, 32'h0000_0007, 4'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
    vt[13] = '{32'h8000_0001, 32'h0000_0001, 4'd6, 32'h0000_0002, 1'b0, 1'b0, 2};

    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.rs1_data_i  = '0;
    bus.rs2_data_i  = '0;
    bus.func_i      = '0;

    // Reset state, then async reset while a result is pending.
    repeat (2) @(negedge clk_i);
    check("rst ready", bus.in_ready_o, 1);
    check("rst valid", bus.out_valid_o, 0);
    arst_i = 1'b0;
    @(negedge clk_i);
    bus.in_valid_i = 1'b1;
    bus.rs1_data_i = 32'd5;
    bus.rs2_data_i = 32'd6;
    bus.func_i     = 4'd4;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    check("pre_rst valid", bus.out_valid_o, 1);
    check("pre_rst data", bus.rd_data_o, 32'd11);
    #2 arst_i = 1'b1;
    #1;
    check("async_rst outs", {bus.out_valid_o, bus.in_ready_o, bus.zero_o, bus.err_o}, 4'b0100);
    check("async_rst data", bus.rd_data_o, 32'd0);
    @(negedge clk_i);
    arst_i = 1'b0;
    @(negedge clk_i);

    // Directed vector table.
    for (int i = 0; i < 14; i++)
      do_op(vt[i].a, vt[i].b, vt[i].f, vt[i].r, vt[i].z, vt[i].e, vt[i].lat, i % 3,
            $sformatf("vec%0d", i));

    // Backpressure with a second request waiting.
    bus.in_valid_i = 1'b1;
    bus.rs1_data_i = 32'd7;
    bus.rs2_data_i = 32'd8;
    bus.func_i     = 4'd4;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.rs1_data_i = 32'd100;
    bus.rs2_data_i = 32'd1;
    bus.func_i     = 4'd5;
    busy_ok   = 1'b1;
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.rd_data_o !== 32'd15 || !bus.out_valid_o) stable_ok = 1'b0;
      if (bus.in_ready_o) busy_ok = 1'b0;
      @(negedge clk_i);
    end
    check("bp stable", stable_ok, 1);
    check("bp no_accept", busy_ok, 1);
    bus.out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.out_ready_i = 1'b0;
    check("bp idle_after", {bus.in_ready_o, bus.out_valid_o}, 2'b10);
    @(posedge clk_i);
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    check("bp second valid", bus.out_valid_o, 1);
    check("bp second data", bus.rd_data_o, 32'd99);
    bus.out_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.out_ready_i = 1'b0;

    // Abort a long shift with reset; nothing may come out.
    bus.in_valid_i = 1'b1;
    bus.rs1_data_i = 32'hFFFF_0000;
    bus.rs2_data_i = 32'd20;
    bus.func_i     = 4'd7;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.in_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("abort busy", bus.in_ready_o, 0);
    #2 arst_i = 1'b1;
    #1;
    check("abort rst", {bus.out_valid_o, bus.in_ready_o}, 2'b01);
    @(negedge clk_i);
    arst_i   = 1'b0;
    no_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk_i);
      if (bus.out_valid_o) no_valid = 1'b0;
    end
    check("abort no_result", no_valid, 1);
    do_op(32'd2, 32'd3, 4'd4, 32'd5, 1'b0, 1'b0, 1, 0, "post_abort add");

    // Random ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = '0;
      if ($urandom_range(0, 5) == 0) rf = 4'($urandom_range(8, 15));
      else                            rf = 4'($urandom_range(0, 7));
      ref_op(ra, rb, rf, rr, rz, re, rlat);
      do_op(ra, rb, rf, rr, rz, re, rlat, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
